// File: rtl/wb_port_arbiter.sv
// Shares the RF write port and HI/LO write enables between the WB stage and the MDU,
// buffering MDU completions. Optional stats counters: define WB_ARB_STATS_EN.
module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BUF_DEPTH = 2,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_rf_en,
  input  logic [ADDR_W-1:0] wb_rf_addr,
  input  logic [DATA_W-1:0] wb_rf_data,
  input  logic              wb_hi_en,
  input  logic              wb_lo_en,
  input  logic [DATA_W-1:0] wb_hi_data,
  input  logic [DATA_W-1:0] wb_lo_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic              mdu_rf_en,
  input  logic [ADDR_W-1:0] mdu_rf_addr,
  input  logic [DATA_W-1:0] mdu_rf_data,
  input  logic              mdu_hi_en,
  input  logic              mdu_lo_en,
  input  logic [DATA_W-1:0] mdu_hi_data,
  input  logic [DATA_W-1:0] mdu_lo_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              hi_we,
  output logic [DATA_W-1:0] hi_wdata,
  output logic              lo_we,
  output logic [DATA_W-1:0] lo_wdata,
  output logic              stall_pipe,
  output logic              busy
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       stat_force_cnt,
  output logic [15:0]       stat_conflict_cnt
`endif
);

  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_FORCE  = 1'b1;

  // MDU completion FIFO storage (data only, never reset)
  logic              buf_rf_en   [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_rf_addr [BUF_DEPTH];
  logic [DATA_W-1:0] buf_rf_data [BUF_DEPTH];
  logic              buf_hi_en   [BUF_DEPTH];
  logic              buf_lo_en   [BUF_DEPTH];
  logic [DATA_W-1:0] buf_hi_data [BUF_DEPTH];
  logic [DATA_W-1:0] buf_lo_data [BUF_DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic [0:0]        state;

  logic              full, head_valid, push, pop;
  logic              pipe_go, head_go, conflict;
  logic              h_rf_en, h_hi_en, h_lo_en;
  logic [ADDR_W-1:0] h_rf_addr;
  logic [DATA_W-1:0] h_rf_data, h_hi_data, h_lo_data;

  logic              rf_we_p1, hi_we_p1, lo_we_p1;
  logic [ADDR_W-1:0] rf_waddr_p1;
  logic [DATA_W-1:0] rf_wdata_p1, hi_wdata_p1, lo_wdata_p1;

  assign full       = (count == FULL_CNT);
  assign head_valid = (count != '0);
  assign mdu_ready  = !full;
  assign busy       = head_valid;
  assign stall_pipe = (state == ST_FORCE);

  assign h_rf_en   = buf_rf_en[rd_ptr];
  assign h_rf_addr = buf_rf_addr[rd_ptr];
  assign h_rf_data = buf_rf_data[rd_ptr];
  assign h_hi_en   = buf_hi_en[rd_ptr];
  assign h_lo_en   = buf_lo_en[rd_ptr];
  assign h_hi_data = buf_hi_data[rd_ptr];
  assign h_lo_data = buf_lo_data[rd_ptr];

  // In FORCE the pipeline is ignored, so conflict is only meaningful in NORMAL
  assign pipe_go  = (state == ST_NORMAL);
  assign conflict = head_valid && pipe_go &&
                    ((wb_rf_en && h_rf_en) || (wb_hi_en && h_hi_en) || (wb_lo_en && h_lo_en));
  assign head_go  = head_valid && !conflict;
  assign pop      = head_go;
  assign push     = mdu_valid && !full;
  assign wait_inc = wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_rf_en[wr_ptr]   <= mdu_rf_en;
      buf_rf_addr[wr_ptr] <= mdu_rf_addr;
      buf_rf_data[wr_ptr] <= mdu_rf_data;
      buf_hi_en[wr_ptr]   <= mdu_hi_en;
      buf_lo_en[wr_ptr]   <= mdu_lo_en;
      buf_hi_data[wr_ptr] <= mdu_hi_data;
      buf_lo_data[wr_ptr] <= mdu_lo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_NORMAL;
      wait_cnt <= '0;
    end else if (state == ST_FORCE) begin
      state    <= ST_NORMAL;
      wait_cnt <= '0;
    end else if (conflict) begin
      wait_cnt <= wait_inc;
      if (wait_inc == WAIT_LIM) state <= ST_FORCE;
    end else if (pop) begin
      wait_cnt <= '0;
    end
  end

  // Stage p1: registered write ports; winners never overlap on a resource
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_p1    <= 1'b0;
      hi_we_p1    <= 1'b0;
      lo_we_p1    <= 1'b0;
      rf_waddr_p1 <= '0;
      rf_wdata_p1 <= '0;
      hi_wdata_p1 <= '0;
      lo_wdata_p1 <= '0;
    end else begin
      rf_we_p1 <= 1'b0;
      hi_we_p1 <= 1'b0;
      lo_we_p1 <= 1'b0;
      if (pipe_go && wb_rf_en) begin
        rf_we_p1    <= (wb_rf_addr != '0);
        rf_waddr_p1 <= wb_rf_addr;
        rf_wdata_p1 <= wb_rf_data;
      end else if (head_go && h_rf_en) begin
        rf_we_p1    <= (h_rf_addr != '0);
        rf_waddr_p1 <= h_rf_addr;
        rf_wdata_p1 <= h_rf_data;
      end
      if (pipe_go && wb_hi_en) begin
        hi_we_p1    <= 1'b1;
        hi_wdata_p1 <= wb_hi_data;
      end else if (head_go && h_hi_en) begin
        hi_we_p1    <= 1'b1;
        hi_wdata_p1 <= h_hi_data;
      end
      if (pipe_go && wb_lo_en) begin
        lo_we_p1    <= 1'b1;
        lo_wdata_p1 <= wb_lo_data;
      end else if (head_go && h_lo_en) begin
        lo_we_p1    <= 1'b1;
        lo_wdata_p1 <= h_lo_data;
      end
    end
  end

  assign rf_we    = rf_we_p1;
  assign rf_waddr = rf_waddr_p1;
  assign rf_wdata = rf_wdata_p1;
  assign hi_we    = hi_we_p1;
  assign hi_wdata = hi_wdata_p1;
  assign lo_we    = lo_we_p1;
  assign lo_wdata = lo_wdata_p1;

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_force_cnt    <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (conflict && (wait_inc == WAIT_LIM) && (stat_force_cnt != 16'hFFFF))
        stat_force_cnt <= stat_force_cnt + 16'd1;
      if (conflict && (stat_conflict_cnt != 16'hFFFF))
        stat_conflict_cnt <= stat_conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default parameters: BUF_DEPTH=2, MAX_WAIT=4).
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_rf_en, wb_hi_en, wb_lo_en;
  logic [ADDR_W-1:0] wb_rf_addr;
  logic [DATA_W-1:0] wb_rf_data, wb_hi_data, wb_lo_data;
  logic              mdu_valid, mdu_ready;
  logic              mdu_rf_en, mdu_hi_en, mdu_lo_en;
  logic [ADDR_W-1:0] mdu_rf_addr;
  logic [DATA_W-1:0] mdu_rf_data, mdu_hi_data, mdu_lo_data;
  logic              rf_we, hi_we, lo_we, stall_pipe, busy;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata, hi_wdata, lo_wdata;
`ifdef WB_ARB_STATS_EN
  logic [15:0]       stat_force_cnt, stat_conflict_cnt;
`endif

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk(clk), .reset(reset),
    .wb_rf_en(wb_rf_en), .wb_rf_addr(wb_rf_addr), .wb_rf_data(wb_rf_data),
    .wb_hi_en(wb_hi_en), .wb_lo_en(wb_lo_en),
    .wb_hi_data(wb_hi_data), .wb_lo_data(wb_lo_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_rf_en(mdu_rf_en), .mdu_rf_addr(mdu_rf_addr), .mdu_rf_data(mdu_rf_data),
    .mdu_hi_en(mdu_hi_en), .mdu_lo_en(mdu_lo_en),
    .mdu_hi_data(mdu_hi_data), .mdu_lo_data(mdu_lo_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_we(hi_we), .hi_wdata(hi_wdata), .lo_we(lo_we), .lo_wdata(lo_wdata),
    .stall_pipe(stall_pipe), .busy(busy)
`ifdef WB_ARB_STATS_EN
    , .stat_force_cnt(stat_force_cnt), .stat_conflict_cnt(stat_conflict_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_rf_en = 0; wb_hi_en = 0; wb_lo_en = 0;
    wb_rf_addr = '0; wb_rf_data = '0; wb_hi_data = '0; wb_lo_data = '0;
    mdu_valid = 0; mdu_rf_en = 0; mdu_hi_en = 0; mdu_lo_en = 0;
    mdu_rf_addr = '0; mdu_rf_data = '0; mdu_hi_data = '0; mdu_lo_data = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_hi_we", hi_we, 0);
    chk("rst_lo_we", lo_we, 0);
    chk("rst_stall", stall_pipe, 0);
    chk("rst_ready", mdu_ready, 1);
    chk("rst_busy", busy, 0);

    // Independent resources: pipeline RF alongside MDU HI/LO head
    mdu_valid = 1; mdu_hi_en = 1; mdu_lo_en = 1; mdu_hi_data = 32'hAA; mdu_lo_data = 32'hBB;
    tick();
    chk("ind_push_busy", busy, 1);
    chk("ind_push_hi_we", hi_we, 0);
    idle_inputs();
    wb_rf_en = 1; wb_rf_addr = 5'd3; wb_rf_data = 32'h11;
    tick();
    chk("ind_rf_we", rf_we, 1);
    chk("ind_rf_waddr", rf_waddr, 3);
    chk("ind_rf_wdata", rf_wdata, 32'h11);
    chk("ind_hi_we", hi_we, 1);
    chk("ind_hi_wdata", hi_wdata, 32'hAA);
    chk("ind_lo_we", lo_we, 1);
    chk("ind_lo_wdata", lo_wdata, 32'hBB);
    chk("ind_busy", busy, 0);
    idle_inputs();
    tick();
    chk("ind_idle_rf_we", rf_we, 0);

    // Conflict then free on RF
    wb_rf_en = 1; wb_rf_addr = 5'd2; wb_rf_data = 32'h22;
    mdu_valid = 1; mdu_rf_en = 1; mdu_rf_addr = 5'd7; mdu_rf_data = 32'h55;
    tick();
    chk("cf_pipe_addr0", rf_waddr, 2);
    mdu_valid = 0; mdu_rf_en = 0;
    tick();
    chk("cf_pipe_addr1", rf_waddr, 2);
    chk("cf_held_busy", busy, 1);
    chk("cf_stall_a", stall_pipe, 0);
    wb_rf_en = 0;
    tick();
    chk("cf_mdu_we", rf_we, 1);
    chk("cf_mdu_addr", rf_waddr, 7);
    chk("cf_mdu_data", rf_wdata, 32'h55);
    chk("cf_stall_b", stall_pipe, 0);
    chk("cf_busy", busy, 0);
    idle_inputs();
    tick();

    // Forced grant after 4 HI conflict cycles
    wb_hi_en = 1; wb_hi_data = 32'h1000;
    mdu_valid = 1; mdu_hi_en = 1; mdu_hi_data = 32'hCAFE;
    tick();
    chk("fg_hi0", hi_wdata, 32'h1000);
    mdu_valid = 0; mdu_hi_en = 0;
    for (int i = 1; i <= 4; i++) begin
      wb_hi_data = 32'h1000 + i;
      tick();
      chk($sformatf("fg_stall%0d", i), stall_pipe, (i == 4));
      chk($sformatf("fg_hi%0d", i), hi_wdata, 32'h1000 + i);
    end
    tick();
    chk("fg_stall_end", stall_pipe, 0);
    chk("fg_mdu_we", hi_we, 1);
    chk("fg_mdu_data", hi_wdata, 32'hCAFE);
    tick();
    chk("fg_resume_we", hi_we, 1);
    chk("fg_resume_data", hi_wdata, 32'h1004);
    chk("fg_busy", busy, 0);
    idle_inputs();
    tick();

    // Full / backpressure on LO
    wb_lo_en = 1; wb_lo_data = 32'h2000;
    mdu_valid = 1; mdu_lo_en = 1; mdu_lo_data = 32'hD1;
    tick();
    chk("fu_ready1", mdu_ready, 1);
    mdu_lo_data = 32'hD2;
    tick();
    chk("fu_ready2", mdu_ready, 0);
    mdu_lo_data = 32'hD3;
    tick();
    chk("fu_ready3", mdu_ready, 0);
    chk("fu_pipe_lo", lo_wdata, 32'h2000);
    wb_lo_en = 0;
    tick();
    chk("fu_pop1", lo_wdata, 32'hD1);
    chk("fu_ready4", mdu_ready, 1);
    tick();
    chk("fu_pop2", lo_wdata, 32'hD2);
    chk("fu_busy_a", busy, 1);
    mdu_valid = 0; mdu_lo_en = 0;
    tick();
    chk("fu_pop3", lo_wdata, 32'hD3);
    chk("fu_busy_b", busy, 0);
    tick();
    chk("fu_lo_idle", lo_we, 0);

    // RF writes to r0 are dropped
    idle_inputs();
    mdu_valid = 1; mdu_rf_en = 1; mdu_rf_addr = 5'd0; mdu_rf_data = 32'h77;
    tick();
    idle_inputs();
    tick();
    chk("r0_mdu_we", rf_we, 0);
    chk("r0_mdu_busy", busy, 0);
    wb_rf_en = 1; wb_rf_addr = 5'd0; wb_rf_data = 32'h88;
    tick();
    chk("r0_pipe_we", rf_we, 0);
    idle_inputs();
    tick();

    // Reset with two entries pending
    wb_rf_en = 1; wb_rf_addr = 5'd4; wb_rf_data = 32'h44;
    mdu_valid = 1; mdu_rf_en = 1; mdu_rf_addr = 5'd9; mdu_rf_data = 32'h99;
    tick();
    mdu_rf_addr = 5'd10; mdu_rf_data = 32'hA0;
    tick();
    chk("mr_full", mdu_ready, 0);
    idle_inputs();
    reset = 1'b1;
    tick();
    chk("mr_busy", busy, 0);
    chk("mr_ready", mdu_ready, 1);
    chk("mr_rf_we0", rf_we, 0);
    reset = 1'b0;
    tick();
    chk("mr_rf_we1", rf_we, 0);
    tick();
    chk("mr_rf_we2", rf_we, 0);
    chk("mr_busy2", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
